uart_tx_param: RTL and testbench

Parametrised UART transmitter: serialises a DATA_WIDTH-bit word into start / data (LSB first) / optional parity / one or two stop bits on TX_OUT. Bit period is set at run time by a prescale value. An optional input FIFO queues frames instead of discarding them while busy. It sits between the parallel host-side producer and the serial pin, alongside the UART receiver.

---
 rtl/uart_pkg.sv | 16 +
 rtl/uart_tx_fifo.sv | 76 +++++++
 rtl/uart_tx_param.sv | 211 +++++++++++++++++++++
 tb/tb_uart_tx_param.sv | 181 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared FSM state type and line constants for the UART transmitter
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } tx_state_e;

  localparam logic PAR_EVEN  = 1'b0;
  localparam logic PAR_ODD   = 1'b1;
  localparam logic LINE_IDLE = 1'b1;

endpackage

// File: rtl/uart_tx_fifo.sv
// rtl/uart_tx_fifo.sv - synchronous frame FIFO with registered full/multi flags
// The head entry is the frame on the line; o_next exposes the entry behind it.
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_next,
  output logic             o_full,
  output logic             o_multi
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW-1:0]    w_rd_next;
  logic [AW:0]      r_count;
  logic [AW:0]      w_count_nxt;
  logic             r_full;
  logic             r_empty;
  logic             r_multi;
  logic             w_push;
  logic             w_pop;

  assign w_push = i_push && !r_full;
  assign w_pop  = i_pop && !r_empty;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 1'b1;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      r_full   <= 1'b0;
      r_empty  <= 1'b1;
      r_multi  <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      r_count <= w_count_nxt;
      r_full  <= (w_count_nxt == (AW+1)'(DEPTH));
      r_empty <= (w_count_nxt == '0);
      r_multi <= (w_count_nxt > (AW+1)'(1));
    end
  end

  always_ff @(posedge i_clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign w_rd_next = r_rd_ptr + 1'b1;
  assign o_next    = r_mem[w_rd_next];
  assign o_full    = r_full;
  assign o_multi   = r_multi;

endmodule

// File: rtl/uart_tx_param.sv
// rtl/uart_tx_param.sv - parametrised UART transmitter (start/data/parity/stop, run-time prescale)
// Optional input FIFO enabled by defining UART_TX_FIFO_EN.
module uart_tx_param
  import uart_pkg::*;
#(
  parameter int DATA_WIDTH     = 8,
  parameter int PRESCALE_WIDTH = 8,
  parameter int FIFO_DEPTH     = 4
) (
  input  logic                      CLK,
  input  logic                      RST,
  input  logic [DATA_WIDTH-1:0]     P_DATA,
  input  logic                      DATA_VALID,
  input  logic                      PAR_EN,
  input  logic                      PAR_TYP,
  input  logic                      STOP_2,
  input  logic [PRESCALE_WIDTH-1:0] PRESCALE,
  output logic                      TX_OUT,
  output logic                      BUSY,
  output logic                      READY
);

  localparam int BW = $clog2(DATA_WIDTH);

  typedef struct packed {
    logic                      stop_2;
    logic                      par_typ;
    logic                      par_en;
    logic [PRESCALE_WIDTH-1:0] prescale;
    logic [DATA_WIDTH-1:0]     data;
  } frame_t;

  function automatic logic [PRESCALE_WIDTH-1:0] reload_of(input logic [PRESCALE_WIDTH-1:0] p);
    return (p == '0) ? '0 : p - 1'b1;
  endfunction

  tx_state_e                 r_state;
  tx_state_e                 w_state_nxt;
  logic                      r_tx;
  logic                      w_tx_nxt;
  logic                      r_busy;
  logic                      w_busy_nxt;
  logic [PRESCALE_WIDTH-1:0] r_pcnt;
  logic [PRESCALE_WIDTH-1:0] w_pcnt_nxt;
  logic [BW-1:0]             r_bitcnt;
  logic [BW-1:0]             w_bitcnt_nxt;
  logic [BW-1:0]             w_bitcnt_inc;
  logic                      r_stopcnt;
  logic                      w_stopcnt_nxt;
  logic [DATA_WIDTH-1:0]     r_data;
  logic                      r_par_en;
  logic                      r_par_typ;
  logic                      r_stop2;
  logic [PRESCALE_WIDTH-1:0] r_reload;
  logic                      w_load;
  frame_t                    w_load_frame;
  frame_t                    w_in;
  frame_t                    w_chain_src;
  logic                      w_chain;
  logic                      w_accept;
  logic                      w_bit_end;
  logic                      w_stop_done;
  logic                      w_parity;

  assign w_in         = {STOP_2, PAR_TYP, PAR_EN, PRESCALE, P_DATA};
  assign w_bit_end    = (r_pcnt == '0);
  assign w_stop_done  = w_bit_end && !(r_stop2 && !r_stopcnt);
  assign w_bitcnt_inc = r_bitcnt + 1'b1;
  assign w_parity     = (^r_data) ^ (r_par_typ == PAR_ODD);

`ifdef UART_TX_FIFO_EN
  logic   w_full;
  logic   w_multi;
  frame_t w_fifo_next;

  // The in-flight frame keeps its FIFO slot until its last stop bit ends.
  assign w_accept    = DATA_VALID && !w_full;
  assign READY       = !w_full;
  assign w_chain     = w_multi || w_accept;
  assign w_chain_src = w_multi ? w_fifo_next : w_in;

  uart_tx_fifo #(
    .WIDTH ($bits(frame_t)),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (CLK),
    .i_rst_n (RST),
    .i_push  (w_accept),
    .i_wdata (w_in),
    .i_pop   ((r_state == STOP) && w_stop_done),
    .o_next  (w_fifo_next),
    .o_full  (w_full),
    .o_multi (w_multi)
  );
`else
  assign w_accept    = DATA_VALID && !r_busy;
  assign READY       = !r_busy;
  assign w_chain     = 1'b0;
  assign w_chain_src = w_in;
`endif

  always_comb begin
    w_state_nxt   = r_state;
    w_tx_nxt      = r_tx;
    w_busy_nxt    = r_busy;
    w_pcnt_nxt    = w_bit_end ? r_pcnt : r_pcnt - 1'b1;
    w_bitcnt_nxt  = r_bitcnt;
    w_stopcnt_nxt = r_stopcnt;
    w_load        = 1'b0;
    w_load_frame  = w_in;
    case (r_state)
      IDLE: begin
        w_tx_nxt   = LINE_IDLE;
        w_busy_nxt = 1'b0;
        if (w_accept) begin
          w_load      = 1'b1;
          w_state_nxt = START;
          w_tx_nxt    = 1'b0;
          w_busy_nxt  = 1'b1;
          w_pcnt_nxt  = reload_of(PRESCALE);
        end
      end
      START: begin
        if (w_bit_end) begin
          w_state_nxt  = DATA;
          w_bitcnt_nxt = '0;
          w_tx_nxt     = r_data[0];
          w_pcnt_nxt   = r_reload;
        end
      end
      DATA: begin
        if (w_bit_end) begin
          w_pcnt_nxt = r_reload;
          if (r_bitcnt == BW'(DATA_WIDTH - 1)) begin
            w_stopcnt_nxt = 1'b0;
            w_state_nxt   = r_par_en ? PARITY : STOP;
            w_tx_nxt      = r_par_en ? w_parity : LINE_IDLE;
          end else begin
            w_bitcnt_nxt = w_bitcnt_inc;
            w_tx_nxt     = r_data[w_bitcnt_inc];
          end
        end
      end
      PARITY: begin
        if (w_bit_end) begin
          w_state_nxt   = STOP;
          w_stopcnt_nxt = 1'b0;
          w_tx_nxt      = LINE_IDLE;
          w_pcnt_nxt    = r_reload;
        end
      end
      STOP: begin
        if (w_bit_end && !w_stop_done) begin
          w_stopcnt_nxt = 1'b1;
          w_pcnt_nxt    = r_reload;
        end else if (w_stop_done) begin
          if (w_chain) begin
            w_load       = 1'b1;
            w_load_frame = w_chain_src;
            w_state_nxt  = START;
            w_tx_nxt     = 1'b0;
            w_pcnt_nxt   = reload_of(w_chain_src.prescale);
          end else begin
            w_state_nxt = IDLE;
            w_tx_nxt    = LINE_IDLE;
            w_busy_nxt  = 1'b0;
          end
        end
      end
      default: begin
        w_state_nxt = IDLE;
        w_tx_nxt    = LINE_IDLE;
        w_busy_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state   <= IDLE;
      r_tx      <= LINE_IDLE;
      r_busy    <= 1'b0;
      r_pcnt    <= '0;
      r_bitcnt  <= '0;
      r_stopcnt <= 1'b0;
      r_data    <= '0;
      r_par_en  <= 1'b0;
      r_par_typ <= 1'b0;
      r_stop2   <= 1'b0;
      r_reload  <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_tx      <= w_tx_nxt;
      r_busy    <= w_busy_nxt;
      r_pcnt    <= w_pcnt_nxt;
      r_bitcnt  <= w_bitcnt_nxt;
      r_stopcnt <= w_stopcnt_nxt;
      if (w_load) begin
        r_data    <= w_load_frame.data;
        r_par_en  <= w_load_frame.par_en;
        r_par_typ <= w_load_frame.par_typ;
        r_stop2   <= w_load_frame.stop_2;
        r_reload  <= reload_of(w_load_frame.prescale);
      end
    end
  end

  assign TX_OUT = r_tx;
  assign BUSY   = r_busy;

endmodule

// File: tb/tb_uart_tx_param.sv
// tb/tb_uart_tx_param.sv - self-checking bench for uart_tx_param against a bit-list line model
module tb_uart_tx_param;
  import uart_pkg::*;

  logic       CLK = 1'b0;
  logic       RST;
  logic [7:0] P_DATA;
  logic       DATA_VALID;
  logic       PAR_EN;
  logic       PAR_TYP;
  logic       STOP_2;
  logic [7:0] PRESCALE;
  logic       TX_OUT;
  logic       BUSY;
  logic       READY;

  int n_checks = 0;
  int n_errors = 0;
  int inj_a    = -1;
  int inj_b    = -1;
  bit exp_bits[$];

  uart_tx_param #(
    .DATA_WIDTH     (8),
    .PRESCALE_WIDTH (8),
    .FIFO_DEPTH     (4)
  ) dut (
    .CLK        (CLK),
    .RST        (RST),
    .P_DATA     (P_DATA),
    .DATA_VALID (DATA_VALID),
    .PAR_EN     (PAR_EN),
    .PAR_TYP    (PAR_TYP),
    .STOP_2     (STOP_2),
    .PRESCALE   (PRESCALE),
    .TX_OUT     (TX_OUT),
    .BUSY       (BUSY),
    .READY      (READY)
  );

  always #5 CLK = ~CLK;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Line model: every frame is a list of bit levels, each held for p clocks.
  task automatic append_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                              input logic s2, input int p);
    bit lvl[$];
    lvl.push_back(1'b0);
    for (int i = 0; i < 8; i++) lvl.push_back(d[i]);
    if (pen) lvl.push_back((($countones(d) % 2) == 1) ^ (ptyp == PAR_ODD));
    lvl.push_back(1'b1);
    if (s2) lvl.push_back(1'b1);
    foreach (lvl[i]) for (int r = 0; r < p; r++) exp_bits.push_back(lvl[i]);
  endtask

  task automatic idle_check(input int n, input string tag);
    for (int k = 0; k < n; k++) begin
      @(negedge CLK);
      check_val({tag, ".idle_tx"}, TX_OUT, 1);
      check_val({tag, ".idle_busy"}, BUSY, 0);
    end
  endtask

  task automatic run_frame(input logic [7:0] d, input logic pen, input logic ptyp,
                           input logic s2, input logic [7:0] presc, input string tag);
    int p;
    p = (presc == 0) ? 1 : int'(presc);
    exp_bits.delete();
    append_frame(d, pen, ptyp, s2, p);
    @(negedge CLK);
    P_DATA = d; PAR_EN = pen; PAR_TYP = ptyp; STOP_2 = s2; PRESCALE = presc;
    DATA_VALID = 1'b1;
    check_val({tag, ".ready"}, READY, 1);
    for (int k = 0; k < exp_bits.size(); k++) begin
      @(negedge CLK);
      DATA_VALID = 1'b0;
      if (k == 0) begin
        P_DATA = 8'($urandom); PAR_EN = 1'($urandom); PAR_TYP = 1'($urandom);
        STOP_2 = 1'($urandom); PRESCALE = 8'($urandom_range(0, 7));
      end
      check_val({tag, ".tx"}, TX_OUT, exp_bits[k]);
      check_val({tag, ".busy"}, BUSY, 1);
      if (k == inj_a || k == inj_b) begin
        P_DATA = 8'hFF;
        DATA_VALID = 1'b1;
        check_val({tag, ".ready_busy"}, READY, 0);
      end
    end
    @(negedge CLK);
    DATA_VALID = 1'b0;
    check_val({tag, ".end_tx"}, TX_OUT, 1);
    check_val({tag, ".end_busy"}, BUSY, 0);
    check_val({tag, ".end_ready"}, READY, 1);
  endtask

  initial begin
    RST = 1'b0; DATA_VALID = 1'b0; P_DATA = '0; PAR_EN = 1'b0; PAR_TYP = 1'b0;
    STOP_2 = 1'b0; PRESCALE = 8'd1;
    repeat (3) @(negedge CLK);
    check_val("rst.tx", TX_OUT, 1);
    check_val("rst.busy", BUSY, 0);
    check_val("rst.ready", READY, 1);
    RST = 1'b1;
    idle_check(2, "post_rst");

    run_frame(8'h81, 1'b0, 1'b0, 1'b0, 8'd1, "np1s");
    run_frame(8'h81, 1'b1, PAR_EVEN, 1'b0, 8'd1, "par_even");
    run_frame(8'h81, 1'b1, PAR_ODD, 1'b1, 8'd1, "par_odd_2stop");
    run_frame(8'h55, 1'b0, 1'b0, 1'b0, 8'd4, "presc4");
    run_frame(8'h55, 1'b0, 1'b0, 1'b0, 8'd0, "presc0");

`ifndef UART_TX_FIFO_EN
    inj_a = 2;
    inj_b = 9;
    run_frame(8'h81, 1'b0, 1'b0, 1'b0, 8'd1, "busy_drop");
    inj_a = -1;
    inj_b = -1;
    idle_check(12, "busy_drop");
`else
    begin
      logic [7:0] fv [5];
      fv = '{8'h81, 8'h3C, 8'hA5, 8'h0F, 8'hF0};
      exp_bits.delete();
      for (int f = 0; f < 4; f++) append_frame(fv[f], 1'b0, 1'b0, 1'b0, 1);
      @(negedge CLK);
      PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP_2 = 1'b0; PRESCALE = 8'd1;
      P_DATA = fv[0]; DATA_VALID = 1'b1;
      check_val("fifo.ready0", READY, 1);
      for (int k = 0; k < exp_bits.size(); k++) begin
        @(negedge CLK);
        check_val("fifo.tx", TX_OUT, exp_bits[k]);
        check_val("fifo.busy", BUSY, 1);
        if (k < 4) begin
          P_DATA = fv[k+1];
          DATA_VALID = 1'b1;
          check_val("fifo.ready", READY, (k < 3) ? 1 : 0);
        end else begin
          DATA_VALID = 1'b0;
        end
      end
      idle_check(12, "fifo_after");
    end
`endif

    exp_bits.delete();
    append_frame(8'h81, 1'b0, 1'b0, 1'b0, 2);
    @(negedge CLK);
    P_DATA = 8'h81; PAR_EN = 1'b0; PAR_TYP = 1'b0; STOP_2 = 1'b0; PRESCALE = 8'd2;
    DATA_VALID = 1'b1;
    for (int k = 0; k <= 8; k++) begin
      @(negedge CLK);
      DATA_VALID = 1'b0;
      check_val("rst_mid.tx", TX_OUT, exp_bits[k]);
    end
    #2 RST = 1'b0;
    #1;
    check_val("rst_mid.async_tx", TX_OUT, 1);
    check_val("rst_mid.async_busy", BUSY, 0);
    check_val("rst_mid.async_ready", READY, 1);
    @(negedge CLK);
    RST = 1'b1;
    idle_check(3, "rst_mid");
    run_frame(8'h3C, 1'b1, PAR_EVEN, 1'b1, 8'd1, "rst_mid.clean");

    for (int i = 0; i < 20; i++) begin
      run_frame(8'($urandom), 1'($urandom), 1'($urandom), 1'($urandom),
                8'($urandom_range(0, 5)), "rand");
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
